// File: rtl/cache_arbiter.sv
// Two-requester round-robin sequencer in front of the CacheModel data port.
// Define CACHE_ARB_STATS_EN to build the saturating per-requester grant counters.
module cache_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int CACHE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              report_i,
  output logic              cache_write_en,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_write_data,
  output logic              cache_report,
  input  logic [DATA_W-1:0] cache_read_data,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(CACHE_LAT - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              report_pend_q, report_pend_d;
  logic              grant0, grant1;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    grant0         = 1'b0;
    grant1         = 1'b0;
    done0          = 1'b0;
    done1          = 1'b0;
    cache_write_en = 1'b0;
    // A report_i arriving in the clearing cycle still leaves the flag set.
    cache_report   = (state_q == IDLE) && report_pend_q;
    report_pend_d  = report_i || (report_pend_q && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        grant0 = req0 && (!req1 || last_grant_q);
        grant1 = req1 && (!req0 || !last_grant_q);
        if (grant0 || grant1) begin
          last_grant_d = grant1;
          we_d         = grant1 ? we1 : we0;
          addr_d       = grant1 ? addr1 : addr0;
          wdata_d      = grant1 ? wdata1 : wdata0;
          cnt_d        = CNT_INIT;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // cnt starts at CNT_INIT, so that value marks the first access cycle.
        cache_write_en = we_q && (cnt_q == CNT_INIT);
        if (cnt_q == 4'd0) begin
          if (last_grant_q) rdata1_d = cache_read_data;
          else              rdata0_d = cache_read_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        done0   = !last_grant_q;
        done1   = last_grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= 4'd0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      report_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      report_pend_q <= report_pend_d;
    end
  end

  assign cache_address    = addr_q;
  assign cache_write_data = wdata_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;

`ifdef CACHE_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (grant0 && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (grant1 && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0_q <= 16'd0;
      gnt_cnt1_q <= 16'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`else
  assign gnt_cnt0 = 16'd0;
  assign gnt_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a CACHE_LAT=1 instance with a small memory model
// behind it, and a CACHE_LAT=3 instance whose read data is driven cycle by cycle.
module tb_cache_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1;
  logic [31:0] rdata0, rdata1;
  logic        report_i;
  logic        cache_write_en;
  logic [7:0]  cache_address;
  logic [31:0] cache_write_data;
  logic        cache_report;
  logic [31:0] cache_read_data;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  logic        b_req0, b_req1, b_we0, b_we1;
  logic [7:0]  b_addr0, b_addr1;
  logic [31:0] b_wdata0, b_wdata1;
  logic        b_done0, b_done1;
  logic [31:0] b_rdata0, b_rdata1;
  logic        b_report_i;
  logic        b_cache_write_en;
  logic [7:0]  b_cache_address;
  logic [31:0] b_cache_write_data;
  logic        b_cache_report;
  logic [31:0] b_cache_read_data;
  logic [15:0] b_gnt_cnt0, b_gnt_cnt1;

  logic [31:0] mem [0:255];
  int          compared;
  int          mismatched;
  logic [15:0] expCnt;

  cache_arbiter #(.ADDR_W(8), .DATA_W(32), .CACHE_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .report_i(report_i),
    .cache_write_en(cache_write_en), .cache_address(cache_address),
    .cache_write_data(cache_write_data), .cache_report(cache_report),
    .cache_read_data(cache_read_data),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  cache_arbiter #(.ADDR_W(8), .DATA_W(32), .CACHE_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .done0(b_done0), .done1(b_done1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .report_i(b_report_i),
    .cache_write_en(b_cache_write_en), .cache_address(b_cache_address),
    .cache_write_data(b_cache_write_data), .cache_report(b_cache_report),
    .cache_read_data(b_cache_read_data),
    .gnt_cnt0(b_gnt_cnt0), .gnt_cnt1(b_gnt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cache_write_en) mem[cache_address] <= cache_write_data;
  end
  assign cache_read_data = mem[cache_address];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [7:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    report_i   = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    b_req0 = 1'b0; b_req1 = 1'b0; b_we0 = 1'b0; b_we1 = 1'b0;
    b_addr0 = 8'h00; b_addr1 = 8'h00; b_wdata0 = 32'h0; b_wdata1 = 32'h0;
    b_report_i = 1'b0; b_cache_read_data = 32'h0;

    repeat (5) tick();
    checkOutput("rst_done0", {31'b0, done0}, 32'h0);
    checkOutput("rst_done1", {31'b0, done1}, 32'h0);
    checkOutput("rst_we", {31'b0, cache_write_en}, 32'h0);
    checkOutput("rst_addr", {24'b0, cache_address}, 32'h0);
    checkOutput("rst_wdata", cache_write_data, 32'h0);
    checkOutput("rst_report", {31'b0, cache_report}, 32'h0);
    checkOutput("rst_rdata0", rdata0, 32'h0);
    checkOutput("rst_rdata1", rdata1, 32'h0);
    checkOutput("rst_cnt0", {16'b0, gnt_cnt0}, 32'h0);
    checkOutput("rst_cnt1", {16'b0, gnt_cnt1}, 32'h0);
    rst = 1'b0;

    $display("[TB] write from requester 0");
    applyStimulus(1'b1, 1'b1, 8'h20, 32'h00abcdef, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    checkOutput("t1_we", {31'b0, cache_write_en}, 32'h1);
    checkOutput("t1_addr", {24'b0, cache_address}, 32'h20);
    checkOutput("t1_wdata", cache_write_data, 32'h00abcdef);
    checkOutput("t1_done0_early", {31'b0, done0}, 32'h0);
    checkOutput("t1_done1_a", {31'b0, done1}, 32'h0);
    tick();
    checkOutput("t1_done0", {31'b0, done0}, 32'h1);
    checkOutput("t1_done1_b", {31'b0, done1}, 32'h0);
    checkOutput("t1_we_off", {31'b0, cache_write_en}, 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    checkOutput("t1_done0_pulse", {31'b0, done0}, 32'h0);
    checkOutput("t1_addr_hold", {24'b0, cache_address}, 32'h20);

    $display("[TB] read back from requester 1");
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
    tick();
    checkOutput("t2_we", {31'b0, cache_write_en}, 32'h0);
    checkOutput("t2_addr", {24'b0, cache_address}, 32'h20);
    tick();
    checkOutput("t2_done1", {31'b0, done1}, 32'h1);
    checkOutput("t2_done0", {31'b0, done0}, 32'h0);
    checkOutput("t2_rdata1", rdata1, 32'h00abcdef);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    checkOutput("t2_done1_pulse", {31'b0, done1}, 32'h0);

    $display("[TB] merged report requests");
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
    report_i = 1'b1;
    tick();
    checkOutput("t4_rep_access", {31'b0, cache_report}, 32'h0);
    report_i = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h30, 32'h5555aaaa, 1'b1, 1'b0, 8'h20, 32'h0);
    tick();
    checkOutput("t4_done1", {31'b0, done1}, 32'h1);
    checkOutput("t4_rep_done", {31'b0, cache_report}, 32'h0);
    report_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h30, 32'h5555aaaa, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    checkOutput("t4_rep_idle", {31'b0, cache_report}, 32'h1);
    checkOutput("t4_done0_idle", {31'b0, done0}, 32'h0);
    report_i = 1'b0;
    tick();
    checkOutput("t4_rep_once", {31'b0, cache_report}, 32'h0);
    checkOutput("t4_we", {31'b0, cache_write_en}, 32'h1);
    checkOutput("t4_addr", {24'b0, cache_address}, 32'h30);
    checkOutput("t4_wdata", cache_write_data, 32'h5555aaaa);
    tick();
    checkOutput("t4_done0", {31'b0, done0}, 32'h1);
    checkOutput("t4_rep_after", {31'b0, cache_report}, 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();

    $display("[TB] continuous tie round robin");
    rst = 1'b1;
    tick();
    checkOutput("t3_rst_rdata1", rdata1, 32'h0);
    checkOutput("t3_rst_done0", {31'b0, done0}, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 1'b1, 1'b0, 8'h30, 32'h0);
    for (int i = 1; i <= 18; i++) begin
      logic e0, e1;
      tick();
      e0 = (i % 3 == 2) && (((i - 2) / 3) % 2 == 0);
      e1 = (i % 3 == 2) && (((i - 2) / 3) % 2 == 1);
      checkOutput($sformatf("t3_done0_c%0d", i), {31'b0, done0}, {31'b0, e0});
      checkOutput($sformatf("t3_done1_c%0d", i), {31'b0, done1}, {31'b0, e1});
      if (i == 17) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    end
`ifdef CACHE_ARB_STATS_EN
    expCnt = 16'd3;
`else
    expCnt = 16'd0;
`endif
    checkOutput("t3_cnt0", {16'b0, gnt_cnt0}, {16'b0, expCnt});
    checkOutput("t3_cnt1", {16'b0, gnt_cnt1}, {16'b0, expCnt});

    $display("[TB] reset during access");
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h40, 32'h00000077);
    tick();
    checkOutput("t5_we", {31'b0, cache_write_en}, 32'h1);
    checkOutput("t5_addr", {24'b0, cache_address}, 32'h40);
    rst = 1'b1;
    tick();
    checkOutput("t5_done0", {31'b0, done0}, 32'h0);
    checkOutput("t5_done1", {31'b0, done1}, 32'h0);
    checkOutput("t5_we_rst", {31'b0, cache_write_en}, 32'h0);
    checkOutput("t5_addr_rst", {24'b0, cache_address}, 32'h0);
    checkOutput("t5_wdata_rst", cache_write_data, 32'h0);
    checkOutput("t5_report", {31'b0, cache_report}, 32'h0);
    checkOutput("t5_rdata0", rdata0, 32'h0);
    checkOutput("t5_rdata1", rdata1, 32'h0);
    checkOutput("t5_cnt0", {16'b0, gnt_cnt0}, 32'h0);
    checkOutput("t5_cnt1", {16'b0, gnt_cnt1}, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 1'b1, 1'b1, 8'h40, 32'h00000077);
    tick();
    checkOutput("t5_tie_addr", {24'b0, cache_address}, 32'h20);
    checkOutput("t5_tie_we", {31'b0, cache_write_en}, 32'h0);
    checkOutput("t5_no_done1", {31'b0, done1}, 32'h0);
    tick();
    checkOutput("t5_tie_done0", {31'b0, done0}, 32'h1);
    checkOutput("t5_tie_done1", {31'b0, done1}, 32'h0);
    checkOutput("t5_tie_rdata0", rdata0, 32'h00abcdef);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();

    $display("[TB] three-cycle cache latency");
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 8'h5a;
    tick();
    checkOutput("t6_addr_c1", {24'b0, b_cache_address}, 32'h5a);
    checkOutput("t6_we_c1", {31'b0, b_cache_write_en}, 32'h0);
    checkOutput("t6_done_c1", {31'b0, b_done0}, 32'h0);
    b_cache_read_data = 32'haaaa0001;
    tick();
    checkOutput("t6_addr_c2", {24'b0, b_cache_address}, 32'h5a);
    checkOutput("t6_we_c2", {31'b0, b_cache_write_en}, 32'h0);
    checkOutput("t6_done_c2", {31'b0, b_done0}, 32'h0);
    b_cache_read_data = 32'haaaa0002;
    tick();
    checkOutput("t6_addr_c3", {24'b0, b_cache_address}, 32'h5a);
    checkOutput("t6_done_c3", {31'b0, b_done0}, 32'h0);
    b_cache_read_data = 32'haaaa0003;
    tick();
    checkOutput("t6_done0", {31'b0, b_done0}, 32'h1);
    checkOutput("t6_done1", {31'b0, b_done1}, 32'h0);
    checkOutput("t6_rdata0", b_rdata0, 32'haaaa0003);
    b_cache_read_data = 32'haaaa0004;
    b_req0 = 1'b0;
    tick();
    checkOutput("t6_done0_pulse", {31'b0, b_done0}, 32'h0);
    b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 8'h5b; b_wdata0 = 32'h00000099;
    tick();
    checkOutput("t6w_we_c1", {31'b0, b_cache_write_en}, 32'h1);
    checkOutput("t6w_addr", {24'b0, b_cache_address}, 32'h5b);
    checkOutput("t6w_wdata", b_cache_write_data, 32'h00000099);
    tick();
    checkOutput("t6w_we_c2", {31'b0, b_cache_write_en}, 32'h0);
    tick();
    checkOutput("t6w_we_c3", {31'b0, b_cache_write_en}, 32'h0);
    checkOutput("t6w_done_c3", {31'b0, b_done0}, 32'h0);
    tick();
    checkOutput("t6w_done0", {31'b0, b_done0}, 32'h1);
    checkOutput("t6w_report", {31'b0, b_cache_report}, 32'h0);
    b_req0 = 1'b0; b_we0 = 1'b0;
    tick();
    checkOutput("t6w_done0_pulse", {31'b0, b_done0}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
